// File: rtl/count_pkg.sv
// Shared definitions for the triangular sweep sequencer.
// State encoding and default widths used by controller and bench.
package count_pkg;

  localparam int WIDTH_DEF  = 16;
  localparam int PASS_W_DEF = 8;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_UP   = 2'd1;
  localparam logic [1:0] ST_DOWN = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  typedef enum logic [1:0] {
    IDLE = ST_IDLE,
    UP   = ST_UP,
    DOWN = ST_DOWN,
    DONE = ST_DONE
  } state_t;

endpackage

// File: rtl/count_core.sv
// Up/down counter with synchronous load; load takes priority over enable.
// Single-cycle update, no backpressure.
module count_core #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             en,
  input  logic             down,
  output logic [WIDTH-1:0] count
);

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (en) begin
      count <= down ? (count - ONE) : (count + ONE);
    end
  end

endmodule

// File: rtl/count_sweep_ctrl.sv
// Drives count_core through lo->hi->lo sweeps for a latched number of passes.
// Moore outputs from registered state; start only sampled in IDLE, abort wins over start.
module count_sweep_ctrl
  import count_pkg::*;
#(
  parameter int WIDTH  = WIDTH_DEF,
  parameter int PASS_W = PASS_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [WIDTH-1:0]  lo,
  input  logic [WIDTH-1:0]  hi,
  input  logic [PASS_W-1:0] passes,
  output logic [WIDTH-1:0]  count_out,
  output logic              dir,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [PASS_W-1:0] pass_cnt
);

  localparam logic [WIDTH-1:0]  ONE  = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [PASS_W-1:0] PONE = {{(PASS_W-1){1'b0}}, 1'b1};

  state_t state, state_nxt;

  logic [WIDTH-1:0]  lo_q, hi_q;
  logic [PASS_W-1:0] passes_q;
  logic [WIDTH-1:0]  cnt_up, cnt_dn;
  logic [PASS_W-1:0] pass_nxt;
  logic              cfg_ok;
  logic              accept, reject, pass_inc;
  logic              core_load, core_en, core_down;

  assign cfg_ok   = (lo < hi) && (passes != '0);
  assign cnt_up   = count_out + ONE;
  assign cnt_dn   = count_out - ONE;
  assign pass_nxt = pass_cnt + PONE;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Turn-around is decided on the value the counter is about to take,
  // so hi and lo each appear for exactly one cycle per pass.
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    reject    = 1'b0;
    pass_inc  = 1'b0;
    core_load = 1'b0;
    core_en   = 1'b0;
    core_down = 1'b0;
    case (state)
      IDLE: begin
        if (start && !abort) begin
          if (cfg_ok) begin
            accept    = 1'b1;
            core_load = 1'b1;
            state_nxt = UP;
          end else begin
            reject = 1'b1;
          end
        end
      end
      UP: begin
        if (abort) begin
          state_nxt = IDLE;
        end else begin
          core_en = 1'b1;
          if (cnt_up == hi_q) state_nxt = DOWN;
        end
      end
      DOWN: begin
        if (abort) begin
          state_nxt = IDLE;
        end else begin
          core_en   = 1'b1;
          core_down = 1'b1;
          if (cnt_dn == lo_q) begin
            pass_inc  = 1'b1;
            state_nxt = (pass_nxt == passes_q) ? DONE : UP;
          end
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lo_q     <= '0;
      hi_q     <= '0;
      passes_q <= '0;
      pass_cnt <= '0;
      err      <= 1'b0;
    end else begin
      err <= reject;
      if (accept) begin
        lo_q     <= lo;
        hi_q     <= hi;
        passes_q <= passes;
        pass_cnt <= '0;
      end else if (pass_inc) begin
        pass_cnt <= pass_nxt;
      end
    end
  end

  assign busy = (state == UP) || (state == DOWN);
  assign dir  = (state == DOWN);
  assign done = (state == DONE);

  count_core #(
    .WIDTH(WIDTH)
  ) u_core (
    .clk      (clk),
    .rst      (rst),
    .load     (core_load),
    .load_val (lo),
    .en       (core_en),
    .down     (core_down),
    .count    (count_out)
  );

endmodule

// File: tb/tb_count_sweep_ctrl.sv
// Directed bench for count_sweep_ctrl with hand-computed sequences.
module tb_count_sweep_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        start, abort;
  logic [15:0] lo, hi;
  logic [7:0]  passes;
  logic [15:0] count_out;
  logic        dir, busy, done, err;
  logic [7:0]  pass_cnt;

  int n_chk = 0;
  int n_bad = 0;

  count_sweep_ctrl #(.WIDTH(16), .PASS_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .abort     (abort),
    .lo        (lo),
    .hi        (hi),
    .passes    (passes),
    .count_out (count_out),
    .dir       (dir),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .pass_cnt  (pass_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg(input logic [15:0] l, input logic [15:0] h, input logic [7:0] p);
    lo = l; hi = h; passes = p;
  endtask

  // lo=2, hi=5, passes=2 expected trace (accept edge is index 0)
  logic [15:0] seq1 [13] = '{16'd2, 16'd3, 16'd4, 16'd5, 16'd4, 16'd3, 16'd2,
                             16'd3, 16'd4, 16'd5, 16'd4, 16'd3, 16'd2};
  logic        dir1 [13] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0,
                             1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
  logic [15:0] seq5 [7]  = '{16'd0, 16'd1, 16'd2, 16'd3, 16'd2, 16'd1, 16'd0};

  initial begin
    int done_seen;
    int low_seen;

    rst = 1'b0; start = 1'b0; abort = 1'b0;
    cfg(16'd0, 16'd0, 8'd0);
    #2;
    chk("rst_count", count_out, 0);
    chk("rst_busy",  busy, 0);
    chk("rst_dir",   dir, 0);
    chk("rst_done",  done, 0);
    chk("rst_err",   err, 0);
    chk("rst_pass",  pass_cnt, 0);
    tick(); tick();
    rst = 1'b1;
    tick();

    // basic two-pass sweep
    cfg(16'd2, 16'd5, 8'd2);
    start = 1'b1;
    tick();
    start = 1'b0;
    cfg(16'd100, 16'd200, 8'd9);
    for (int i = 0; i < 13; i++) begin
      if (i > 0) tick();
      chk($sformatf("s1_cnt%0d", i),  count_out, seq1[i]);
      chk($sformatf("s1_dir%0d", i),  dir, dir1[i]);
      chk($sformatf("s1_busy%0d", i), busy, (i < 12) ? 1 : 0);
      chk($sformatf("s1_done%0d", i), done, (i == 12) ? 1 : 0);
      chk($sformatf("s1_pass%0d", i), pass_cnt, (i < 6) ? 0 : ((i < 12) ? 1 : 2));
    end
    tick();
    chk("s1_post_done", done, 0);
    chk("s1_post_busy", busy, 0);
    chk("s1_post_cnt",  count_out, 2);

    // rejected configs
    cfg(16'd7, 16'd7, 8'd1);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("e1_err",  err, 1);
    chk("e1_busy", busy, 0);
    chk("e1_cnt",  count_out, 2);
    chk("e1_pass", pass_cnt, 2);
    tick();
    chk("e1_err_clr", err, 0);
    cfg(16'd1, 16'd4, 8'd0);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("e2_err",  err, 1);
    chk("e2_busy", busy, 0);
    chk("e2_cnt",  count_out, 2);
    tick();
    chk("e2_err_clr", err, 0);

    // top-of-range sweep, no wrap past FFFF
    cfg(16'hFF00, 16'hFFFF, 8'd1);
    start = 1'b1;
    tick();
    start = 1'b0;
    cfg(16'd0, 16'd1, 8'd5);
    chk("w_start", count_out, 16'hFF00);
    low_seen = 0;
    for (int i = 0; i < 255; i++) begin
      tick();
      if (count_out < 16'hFF00) low_seen++;
    end
    chk("w_top",     count_out, 16'hFFFF);
    chk("w_top_dir", dir, 1);
    done_seen = 0;
    for (int i = 0; i < 255; i++) begin
      if (done) done_seen++;
      tick();
      if (count_out < 16'hFF00) low_seen++;
    end
    chk("w_nowrap",   low_seen, 0);
    chk("w_done_early", done_seen, 0);
    chk("w_done",     done, 1);
    chk("w_final",    count_out, 16'hFF00);
    tick();

    // abort during second upward run
    cfg(16'd10, 16'd20, 8'd3);
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 25; i++) tick();
    chk("a_pre_cnt",  count_out, 15);
    chk("a_pre_dir",  dir, 0);
    chk("a_pre_pass", pass_cnt, 1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("a_busy", busy, 0);
    chk("a_cnt",  count_out, 15);
    chk("a_pass", pass_cnt, 1);
    chk("a_done", done, 0);
    tick(); tick();
    chk("a_hold_cnt",  count_out, 15);
    chk("a_hold_done", done, 0);

    // abort beats start in IDLE
    cfg(16'd0, 16'd3, 8'd1);
    abort = 1'b1; start = 1'b1;
    tick();
    abort = 1'b0; start = 1'b0;
    chk("as_busy", busy, 0);
    chk("as_err",  err, 0);
    chk("as_cnt",  count_out, 15);

    // lo=0 sweep with start re-pulsed while busy
    start = 1'b1;
    tick();
    start = 1'b0;
    done_seen = 0;
    for (int i = 0; i < 7; i++) begin
      if (i > 0) tick();
      if (i == 2) begin
        cfg(16'd5, 16'd9, 8'd4);
        start = 1'b1;
      end else begin
        start = 1'b0;
      end
      if (done) done_seen++;
      chk($sformatf("b_cnt%0d", i), count_out, seq5[i]);
      chk($sformatf("b_err%0d", i), err, 0);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      if (done) done_seen++;
    end
    chk("b_done_once", done_seen, 1);
    chk("b_idle",      busy, 0);

    // asynchronous reset mid-sweep
    cfg(16'd2, 16'd5, 8'd2);
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 8; i++) tick();
    chk("r_pre_pass", pass_cnt, 1);
    chk("r_pre_cnt",  count_out, 4);
    #2;
    rst = 1'b0;
    #1;
    chk("r_cnt",  count_out, 0);
    chk("r_busy", busy, 0);
    chk("r_pass", pass_cnt, 0);
    @(negedge clk);
    rst = 1'b1;
    tick();
    cfg(16'd1, 16'd2, 8'd1);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("r2_cnt0", count_out, 1);
    tick();
    chk("r2_cnt1", count_out, 2);
    chk("r2_dir1", dir, 1);
    tick();
    chk("r2_cnt2", count_out, 1);
    chk("r2_done", done, 1);
    chk("r2_pass", pass_cnt, 1);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
